// File: rtl/ht_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ht_tx_pkg
//  Description : Shared definitions for the HT preamble scheduler: scheduler
//                state encoding, default timing constants, counter width and
//                small helpers used by the scheduler and its I/Q negator.
//  Revision    : 1.0 - initial release
// ============================================================================
package ht_tx_pkg;

    // Default timing: samples per STF/LTF symbol, generator load time
    // (64 coefficient loads plus IFFT latency) and start handshake timeout.
    localparam int c_sym_len_def       = 80;
    localparam int c_load_cyc_def      = 96;
    localparam int c_start_timeout_def = 15;

    // Shared cycle counter width; wide enough for any of the above.
    localparam int c_cnt_w = 16;

    // Highest legal HT-LTF count.
    localparam logic [2:0] c_max_ltf = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_STF_REQ  = 3'd2,
        ST_STF_OUT  = 3'd3,
        ST_LTF_LOAD = 3'd4,
        ST_LTF_REQ  = 3'd5,
        ST_LTF_OUT  = 3'd6,
        ST_FLUSH    = 3'd7
    } ht_state_e;

    // A transmission is only accepted for 1..4 HT-LTFs.
    function automatic logic nltf_ok(input logic [2:0] n);
        return (n != 3'd0) && (n <= c_max_ltf);
    endfunction

    // Two's-complement negation with the single overflow case (-32768)
    // clamped to +32767.
    function automatic logic [15:0] neg_sat16(input logic [15:0] x);
        return (x == 16'h8000) ? 16'h7FFF : (~x + 16'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ht_iq_negsat.sv
`default_nettype none
// ============================================================================
//  Module      : ht_iq_negsat
//  Description : Combinational saturating negator for a packed complex
//                sample {I[31:16], Q[15:0]}; both halves are negated
//                independently, -32768 maps to +32767.
//  Ports       : i_iq  in  32  packed I/Q sample
//                o_iq  out 32  negated, saturated I/Q sample
//  Revision    : 1.0 - initial release
// ============================================================================
module ht_iq_negsat
    import ht_tx_pkg::*;
(
    input  logic [31:0] i_iq,
    output logic [31:0] o_iq
);

    assign o_iq = {neg_sat16(i_iq[31:16]), neg_sat16(i_iq[15:0])};

endmodule
`default_nettype wire

// File: rtl/ht_preamble_sched.sv
`default_nettype none
// ============================================================================
//  Module      : ht_preamble_sched
//  Description : Sequences the HT preamble: arms STF and LTF generators,
//                waits for their load time, requests output, forwards one
//                STF symbol followed by n_ltf HT-LTF symbols (P-row polarity
//                applied to LTF 2), and cleans up via a generator reset on
//                abort or start timeout.
//  Ports       : clk, rstn                 clock, async active-low reset
//                tx_start, tx_abort, n_ltf arm pulse, cancel, LTF count 1..4
//                obf_stf_in, obf_ltf_in    coefficients sampled on start
//                stf_obf, ltf_obf          latched coefficients to generators
//                stf_* / ltf_*             generator letsgo/give/started/data
//                gen_reset                 sync reset to both generators
//                ht_sample/valid/sym       registered output stream
//                busy, done, err           status
//  Revision    : 1.0 - initial release
// ============================================================================
module ht_preamble_sched
    import ht_tx_pkg::*;
#(
    parameter int LOAD_CYC      = c_load_cyc_def,
    parameter int START_TIMEOUT = c_start_timeout_def,
    parameter int SYM_LEN       = c_sym_len_def
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         tx_start,
    input  logic         tx_abort,
    input  logic [2:0]   n_ltf,
    input  logic [127:0] obf_stf_in,
    input  logic [127:0] obf_ltf_in,
    output logic [127:0] stf_obf,
    output logic [127:0] ltf_obf,
    output logic         stf_letsgo,
    output logic         stf_give,
    input  logic         stf_started,
    input  logic [31:0]  stf_sample,
    output logic         ltf_letsgo,
    output logic         ltf_give,
    input  logic         ltf_started,
    input  logic [31:0]  ltf_sample,
    output logic         gen_reset,
    output logic [31:0]  ht_sample,
    output logic         ht_valid,
    output logic [2:0]   ht_sym,
    output logic         busy,
    output logic         done,
    output logic         err
);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    ht_state_e            r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [2:0]           r_k;
    logic [2:0]           r_nltf;
    logic [127:0]         r_stf_obf;
    logic [127:0]         r_ltf_obf;
    logic                 r_stf_letsgo;
    logic                 r_ltf_letsgo;
    logic                 r_stf_give;
    logic                 r_ltf_give;
    logic                 r_gen_reset;
    logic                 r_boot;
    logic [31:0]          r_ht_sample;
    logic                 r_ht_valid;
    logic [2:0]           r_ht_sym;
    logic                 r_done;
    logic                 r_err;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    ht_state_e            w_state;
    logic [c_cnt_w-1:0]   w_cnt;
    logic [2:0]           w_k;
    logic [2:0]           w_nltf;
    logic                 w_latch;
    logic                 w_stf_letsgo;
    logic                 w_ltf_letsgo;
    logic                 w_stf_give;
    logic                 w_ltf_give;
    logic                 w_gen_reset;
    logic [31:0]          w_sample;
    logic                 w_valid;
    logic [2:0]           w_sym;
    logic                 w_done;
    logic                 w_err;

    logic                 w_load_end;
    logic                 w_sym_end;
    logic                 w_timeout;
    logic                 w_abort;
    logic [31:0]          w_ltf_neg;
    logic [31:0]          w_ltf_data;

    assign w_load_end = (r_cnt == c_cnt_w'(LOAD_CYC - 1));
    assign w_sym_end  = (r_cnt == c_cnt_w'(SYM_LEN - 1));
    assign w_timeout  = (r_cnt == c_cnt_w'(START_TIMEOUT));
    // FLUSH is already the cleanup path, so a further abort there is moot.
    assign w_abort    = tx_abort && (r_state != ST_IDLE) && (r_state != ST_FLUSH);

    ht_iq_negsat u_negsat (
        .i_iq (ltf_sample),
        .o_iq (w_ltf_neg)
    );

    // Second P-matrix row: LTF 2 carries inverted polarity.
    assign w_ltf_data = (r_k == 3'd2) ? w_ltf_neg : ltf_sample;

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state      = r_state;
        w_cnt        = r_cnt;
        w_k          = r_k;
        w_nltf       = r_nltf;
        w_latch      = 1'b0;
        w_stf_letsgo = 1'b0;
        w_ltf_letsgo = 1'b0;
        w_stf_give   = 1'b0;
        w_ltf_give   = 1'b0;
        w_gen_reset  = 1'b0;
        w_sample     = r_ht_sample;
        w_valid      = 1'b0;
        w_sym        = r_ht_sym;
        w_done       = 1'b0;
        w_err        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (tx_start) begin
                    if (nltf_ok(n_ltf)) begin
                        w_latch      = 1'b1;
                        w_nltf       = n_ltf;
                        w_k          = 3'd0;
                        w_stf_letsgo = 1'b1;
                        w_ltf_letsgo = 1'b1;
                        w_cnt        = '0;
                        w_state      = ST_LOAD;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end

            ST_LOAD, ST_LTF_LOAD: begin
                if (w_load_end) begin
                    w_cnt = '0;
                    if (r_state == ST_LOAD) begin
                        w_stf_give = 1'b1;
                        w_state    = ST_STF_REQ;
                    end else begin
                        w_ltf_give = 1'b1;
                        w_state    = ST_LTF_REQ;
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end

            // The cycle in which started first rises already carries
            // sample 0, so it is captured here rather than in *_OUT.
            ST_STF_REQ: begin
                if (stf_started) begin
                    w_sample = stf_sample;
                    w_valid  = 1'b1;
                    w_sym    = 3'd0;
                    w_cnt    = c_cnt_w'(1);
                    w_state  = ST_STF_OUT;
                end else if (w_timeout) begin
                    w_err   = 1'b1;
                    w_cnt   = '0;
                    w_state = ST_FLUSH;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end

            ST_STF_OUT: begin
                w_sample = stf_sample;
                w_valid  = 1'b1;
                w_sym    = 3'd0;
                if (w_sym_end) begin
                    // LTF generator was armed together with STF.
                    w_k        = 3'd1;
                    w_cnt      = '0;
                    w_ltf_give = 1'b1;
                    w_state    = ST_LTF_REQ;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end

            ST_LTF_REQ: begin
                if (ltf_started) begin
                    w_sample = w_ltf_data;
                    w_valid  = 1'b1;
                    w_sym    = r_k;
                    w_cnt    = c_cnt_w'(1);
                    w_state  = ST_LTF_OUT;
                end else if (w_timeout) begin
                    w_err   = 1'b1;
                    w_cnt   = '0;
                    w_state = ST_FLUSH;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end

            ST_LTF_OUT: begin
                w_sample = w_ltf_data;
                w_valid  = 1'b1;
                w_sym    = r_k;
                if (w_sym_end) begin
                    w_cnt = '0;
                    if (r_k < r_nltf) begin
                        w_k          = r_k + 3'd1;
                        w_ltf_letsgo = 1'b1;
                        w_state      = ST_LTF_LOAD;
                    end else begin
                        w_done  = 1'b1;
                        w_state = ST_IDLE;
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end

            ST_FLUSH: begin
                if (r_cnt == c_cnt_w'(1)) begin
                    w_cnt   = '0;
                    w_state = ST_IDLE;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end

            default: begin
                w_cnt   = '0;
                w_state = ST_IDLE;
            end
        endcase

        // Abort overrides every other outcome of this cycle.
        if (w_abort) begin
            w_state      = ST_FLUSH;
            w_cnt        = '0;
            w_valid      = 1'b0;
            w_stf_give   = 1'b0;
            w_ltf_give   = 1'b0;
            w_ltf_letsgo = 1'b0;
            w_done       = 1'b0;
            w_err        = 1'b0;
        end

        // Generators stay in reset through the first cycle after rstn
        // release (r_boot still low) and for the whole of FLUSH.
        w_gen_reset = (w_state == ST_FLUSH) || !r_boot;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    // ------------------------------------------------------------------
    // Counters, latched configuration and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt        <= '0;
            r_k          <= 3'd0;
            r_nltf       <= 3'd0;
            r_stf_obf    <= '0;
            r_ltf_obf    <= '0;
            r_stf_letsgo <= 1'b0;
            r_ltf_letsgo <= 1'b0;
            r_stf_give   <= 1'b0;
            r_ltf_give   <= 1'b0;
            r_gen_reset  <= 1'b1;
            r_boot       <= 1'b0;
            r_ht_sample  <= '0;
            r_ht_valid   <= 1'b0;
            r_ht_sym     <= 3'd0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_cnt        <= w_cnt;
            r_k          <= w_k;
            r_nltf       <= w_nltf;
            if (w_latch) begin
                r_stf_obf <= obf_stf_in;
                r_ltf_obf <= obf_ltf_in;
            end
            r_stf_letsgo <= w_stf_letsgo;
            r_ltf_letsgo <= w_ltf_letsgo;
            r_stf_give   <= w_stf_give;
            r_ltf_give   <= w_ltf_give;
            r_gen_reset  <= w_gen_reset;
            r_boot       <= 1'b1;
            r_ht_sample  <= w_sample;
            r_ht_valid   <= w_valid;
            r_ht_sym     <= w_sym;
            r_done       <= w_done;
            r_err        <= w_err;
        end
    end

    assign stf_obf    = r_stf_obf;
    assign ltf_obf    = r_ltf_obf;
    assign stf_letsgo = r_stf_letsgo;
    assign ltf_letsgo = r_ltf_letsgo;
    assign stf_give   = r_stf_give;
    assign ltf_give   = r_ltf_give;
    assign gen_reset  = r_gen_reset;
    assign ht_sample  = r_ht_sample;
    assign ht_valid   = r_ht_valid;
    assign ht_sym     = r_ht_sym;
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ht_preamble_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ht_preamble_sched
//  Description : Self-checking bench for ht_preamble_sched with simple STF and
//                LTF generator models (started two cycles after give) and a
//                scoreboard of expected {ht_sym, ht_sample} words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ht_preamble_sched;

    logic         clk = 1'b0;
    logic         rstn;
    logic         tx_start;
    logic         tx_abort;
    logic [2:0]   n_ltf;
    logic [127:0] obf_stf_in;
    logic [127:0] obf_ltf_in;
    logic [127:0] stf_obf;
    logic [127:0] ltf_obf;
    logic         stf_letsgo;
    logic         stf_give;
    logic         stf_started;
    logic [31:0]  stf_sample;
    logic         ltf_letsgo;
    logic         ltf_give;
    logic         ltf_started;
    logic [31:0]  ltf_sample;
    logic         gen_reset;
    logic [31:0]  ht_sample;
    logic         ht_valid;
    logic [2:0]   ht_sym;
    logic         busy;
    logic         done;
    logic         err;

    ht_preamble_sched dut (
        .clk         (clk),
        .rstn        (rstn),
        .tx_start    (tx_start),
        .tx_abort    (tx_abort),
        .n_ltf       (n_ltf),
        .obf_stf_in  (obf_stf_in),
        .obf_ltf_in  (obf_ltf_in),
        .stf_obf     (stf_obf),
        .ltf_obf     (ltf_obf),
        .stf_letsgo  (stf_letsgo),
        .stf_give    (stf_give),
        .stf_started (stf_started),
        .stf_sample  (stf_sample),
        .ltf_letsgo  (ltf_letsgo),
        .ltf_give    (ltf_give),
        .ltf_started (ltf_started),
        .ltf_sample  (ltf_sample),
        .gen_reset   (gen_reset),
        .ht_sample   (ht_sample),
        .ht_valid    (ht_valid),
        .ht_sym      (ht_sym),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Sample patterns
    // ------------------------------------------------------------------
    function automatic logic [31:0] stf_pat(input int idx);
        return {16'h1000 + 16'(idx), 16'h2000 + 16'(idx)};
    endfunction

    function automatic logic [31:0] ltf_pat(input int idx);
        return {16'h3000 + 16'(idx), 16'h4000 + 16'(idx)};
    endfunction

    // ------------------------------------------------------------------
    // Generator models: started rises two cycles after give and stays
    // high for 80 samples; gen_reset clears them.
    // ------------------------------------------------------------------
    logic stf_en    = 1'b1;
    logic ltf_const = 1'b0;

    int   s_cd  = -1;
    logic s_act = 1'b0;
    int   s_idx = 0;
    int   l_cd  = -1;
    logic l_act = 1'b0;
    int   l_idx = 0;

    always @(posedge clk) begin
        if (gen_reset) begin
            s_cd  <= -1;
            s_act <= 1'b0;
            s_idx <= 0;
        end else begin
            if (s_act) begin
                if (s_idx == 79) s_act <= 1'b0;
                s_idx <= s_idx + 1;
            end
            if (stf_give && stf_en) s_cd <= 0;
            else if (s_cd == 0) begin
                s_act <= 1'b1;
                s_idx <= 0;
                s_cd  <= -1;
            end
        end
    end

    always @(posedge clk) begin
        if (gen_reset) begin
            l_cd  <= -1;
            l_act <= 1'b0;
            l_idx <= 0;
        end else begin
            if (l_act) begin
                if (l_idx == 79) l_act <= 1'b0;
                l_idx <= l_idx + 1;
            end
            if (ltf_give) l_cd <= 0;
            else if (l_cd == 0) begin
                l_act <= 1'b1;
                l_idx <= 0;
                l_cd  <= -1;
            end
        end
    end

    assign stf_started = s_act;
    assign stf_sample  = s_act ? stf_pat(s_idx) : 32'hDEAD_BEEF;
    assign ltf_started = l_act;
    assign ltf_sample  = l_act ? (ltf_const ? 32'h8000_7FFF : ltf_pat(l_idx)) : 32'hDEAD_BEEF;

    // ------------------------------------------------------------------
    // Scoreboard and event monitor
    // ------------------------------------------------------------------
    logic [34:0] sb_q[$];
    logic [34:0] exp_item;

    int n_err = 0, n_done = 0, n_stf_lg = 0, n_ltf_lg = 0, n_grst = 0, n_valid = 0;
    int give_cyc = 0, err_cyc = 0;

    always @(negedge clk) begin
        if (stf_give)   give_cyc = cyc;
        if (err)        begin n_err++; err_cyc = cyc; end
        if (done)       n_done++;
        if (stf_letsgo) n_stf_lg++;
        if (ltf_letsgo) n_ltf_lg++;
        if (gen_reset)  n_grst++;
        if (ht_valid) begin
            n_valid++;
            tests++;
            if (sb_q.size() != 0) exp_item = sb_q.pop_front();
            else                  exp_item = 'x;
            assert ({ht_sym, ht_sample} === exp_item) else begin
                fails++;
                $error("FAIL sb_out observed=%h expected=%h", {ht_sym, ht_sample}, exp_item);
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_txn(input logic [2:0] n, input logic [127:0] so, input logic [127:0] lo);
        n_ltf      = n;
        obf_stf_in = so;
        obf_ltf_in = lo;
        tx_start   = 1'b1;
        tick();
        tx_start   = 1'b0;
    endtask

    task automatic push_txn(input int n, input logic cm);
        logic [31:0] v;
        for (int i = 0; i < 80; i++) sb_q.push_back({3'd0, stf_pat(i)});
        for (int k = 1; k <= n; k++) begin
            for (int i = 0; i < 80; i++) begin
                if (cm) v = (k == 2) ? 32'h7FFF_8001 : 32'h8000_7FFF;
                else if (k == 2) v = {16'h0 - (16'h3000 + 16'(i)), 16'h0 - (16'h4000 + 16'(i))};
                else v = ltf_pat(i);
                sb_q.push_back({3'(k), v});
            end
        end
    endtask

    task automatic wait_idle(input int bound, input string tag);
        for (int i = 0; i < bound; i++) begin
            tick();
            if (!busy) break;
        end
        chk(tag, 128'(busy), 128'd0);
    endtask

    int b_done, b_err, b_valid, b_stf_lg, b_ltf_lg, b_grst;
    logic found;

    task automatic snap();
        b_done   = n_done;
        b_err    = n_err;
        b_valid  = n_valid;
        b_stf_lg = n_stf_lg;
        b_ltf_lg = n_ltf_lg;
        b_grst   = n_grst;
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        rstn       = 1'b0;
        tx_start   = 1'b0;
        tx_abort   = 1'b0;
        n_ltf      = 3'd0;
        obf_stf_in = '0;
        obf_ltf_in = '0;

        // Reset state
        tick(); tick();
        chk("rst_gen_reset", 128'(gen_reset), 128'd1);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_outs", 128'({ht_valid, ht_sample, ht_sym, done, err, stf_give, ltf_give, stf_letsgo, ltf_letsgo}), 128'd0);
        chk("rst_obf", stf_obf | ltf_obf, 128'd0);
        rstn = 1'b1;
        tick();
        chk("rel_gen_reset_hold", 128'(gen_reset), 128'd1);
        tick();
        chk("rel_gen_reset_drop", 128'(gen_reset), 128'd0);

        // Single LTF, full stream
        snap();
        push_txn(1, 1'b0);
        start_txn(3'd1, 128'hA5A5_0001, 128'h5A5A_0002);
        chk("a_busy", 128'(busy), 128'd1);
        chk("a_stf_letsgo", 128'(stf_letsgo), 128'd1);
        chk("a_ltf_letsgo", 128'(ltf_letsgo), 128'd1);
        chk("a_stf_obf", stf_obf, 128'hA5A5_0001);
        chk("a_ltf_obf", ltf_obf, 128'h5A5A_0002);
        wait_idle(1000, "a_finish");
        chk("a_valid_cnt", 128'(n_valid - b_valid), 128'd160);
        chk("a_done_cnt", 128'(n_done - b_done), 128'd1);
        chk("a_err_cnt", 128'(n_err - b_err), 128'd0);
        chk("a_sb_empty", 128'(sb_q.size()), 128'd0);

        // Two LTFs, saturating polarity inversion on LTF 2
        snap();
        ltf_const = 1'b1;
        push_txn(2, 1'b1);
        start_txn(3'd2, 128'h11, 128'h22);
        wait_idle(1200, "b_finish");
        ltf_const = 1'b0;
        chk("b_ltf_letsgo_cnt", 128'(n_ltf_lg - b_ltf_lg), 128'd2);
        chk("b_valid_cnt", 128'(n_valid - b_valid), 128'd240);
        chk("b_done_cnt", 128'(n_done - b_done), 128'd1);
        chk("b_sb_empty", 128'(sb_q.size()), 128'd0);

        // STF generator never starts: timeout
        snap();
        stf_en = 1'b0;
        start_txn(3'd1, 128'h1, 128'h2);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            if (err) found = 1'b1;
        end
        chk("c_err_seen", 128'(found), 128'd1);
        tick(); tick(); tick();
        chk("c_err_delay", 128'(err_cyc - give_cyc), 128'd16);
        chk("c_gen_reset_cyc", 128'(n_grst - b_grst), 128'd2);
        chk("c_busy", 128'(busy), 128'd0);
        chk("c_done_cnt", 128'(n_done - b_done), 128'd0);
        chk("c_valid_cnt", 128'(n_valid - b_valid), 128'd0);
        stf_en = 1'b1;

        // Abort at STF sample 40, then a clean transmission
        snap();
        for (int i = 0; i < 41; i++) sb_q.push_back({3'd0, stf_pat(i)});
        start_txn(3'd1, 128'h3, 128'h4);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick();
            if (ht_valid && ht_sym == 3'd0 && ht_sample == stf_pat(40)) found = 1'b1;
        end
        chk("d_sample40_seen", 128'(found), 128'd1);
        tx_abort = 1'b1;
        tick();
        tx_abort = 1'b0;
        chk("d_valid_low", 128'(ht_valid), 128'd0);
        chk("d_gen_reset", 128'(gen_reset), 128'd1);
        tick(); tick(); tick();
        chk("d_busy", 128'(busy), 128'd0);
        chk("d_done_cnt", 128'(n_done - b_done), 128'd0);
        chk("d_sb_empty", 128'(sb_q.size()), 128'd0);
        snap();
        push_txn(1, 1'b0);
        start_txn(3'd1, 128'h5, 128'h6);
        wait_idle(1000, "d_restart_finish");
        chk("d_restart_done", 128'(n_done - b_done), 128'd1);
        chk("d_restart_sb", 128'(sb_q.size()), 128'd0);

        // Illegal LTF counts
        snap();
        start_txn(3'd0, 128'h7, 128'h8);
        chk("e_err_n0", 128'(err), 128'd1);
        chk("e_letsgo_n0", 128'({stf_letsgo, ltf_letsgo}), 128'd0);
        chk("e_busy_n0", 128'(busy), 128'd0);
        tick();
        chk("e_err_pulse", 128'(err), 128'd0);
        start_txn(3'd5, 128'h7, 128'h8);
        chk("e_err_n5", 128'(err), 128'd1);
        chk("e_busy_n5", 128'(busy), 128'd0);

        // Start while busy is ignored
        tick();
        snap();
        start_txn(3'd1, 128'hBEEF, 128'hCAFE);
        tick(); tick(); tick();
        start_txn(3'd0, 128'h9999, 128'h8888);
        tick();
        chk("e_busy_err", 128'(n_err - b_err), 128'd0);
        chk("e_busy_letsgo", 128'(n_stf_lg - b_stf_lg), 128'd1);
        chk("e_busy_obf", stf_obf, 128'hBEEF);
        chk("e_busy_state", 128'(busy), 128'd1);
        tx_abort = 1'b1;
        tick();
        tx_abort = 1'b0;
        tick(); tick(); tick();
        chk("e_abort_idle", 128'(busy), 128'd0);
        chk("e_abort_done", 128'(n_done - b_done), 128'd0);

        // Reset in the middle of LTF output
        push_txn(1, 1'b0);
        start_txn(3'd1, 128'hF0, 128'h0F);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick();
            if (ht_valid && ht_sym == 3'd1 && ht_sample == ltf_pat(10)) found = 1'b1;
        end
        chk("f_ltf10_seen", 128'(found), 128'd1);
        #1;
        rstn = 1'b0;
        #1;
        chk("f_outs_zero", 128'({ht_valid, ht_sample, ht_sym, done, err, ltf_give, ltf_letsgo}), 128'd0);
        chk("f_obf_zero", stf_obf | ltf_obf, 128'd0);
        chk("f_gen_reset", 128'(gen_reset), 128'd1);
        chk("f_busy", 128'(busy), 128'd0);
        sb_q.delete();
        tick(); tick();
        rstn = 1'b1;
        tick();
        chk("f_rel_gen_reset", 128'(gen_reset), 128'd1);
        chk("f_rel_idle", 128'(busy), 128'd0);
        tick();
        chk("f_rel_gen_reset_drop", 128'(gen_reset), 128'd0);
        chk("f_rel_valid", 128'(ht_valid), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ht_preamble_sched.md
HT_PREAMBLE_SCHED -- requirements
Module: ht_preamble_sched

Interface
REQ-001 Parameter LOAD_CYC, default 96: cycles waited after letsgo before requesting generator output (64 loads plus IFFT latency).
REQ-002 Parameter START_TIMEOUT, default 15: cycles allowed between a givemeoutput pulse and the matching started flag.
REQ-003 Parameter SYM_LEN, default 80: samples forwarded per STF or LTF symbol.
REQ-004 Ports (name dir width meaning): clk in 1 sole clock; rstn in 1 asynchronous active-low reset.
REQ-005 tx_start in 1 single-cycle arm pulse; tx_abort in 1 cancel request; n_ltf in 3 HT-LTF count, valid 1..4.
REQ-006 obf_stf_in in 128, obf_ltf_in in 128: obfuscation coefficients, sampled on accepted tx_start.
REQ-007 stf_obf out 128, ltf_obf out 128: latched coefficients driving the generators' obf_coeff.
REQ-008 stf_letsgo out 1, stf_give out 1, stf_started in 1, stf_sample in 32: STF generator control and data.
REQ-009 ltf_letsgo out 1, ltf_give out 1, ltf_started in 1, ltf_sample in 32: LTF generator control and data.
REQ-010 gen_reset out 1: active-high synchronous reset to both generators.
REQ-011 ht_sample out 32 {I[31:16], Q[15:0]}; ht_valid out 1; ht_sym out 3 (0=STF, 1..4=LTF index).
REQ-012 busy out 1; done out 1 pulse; err out 1 pulse.

Function
REQ-013 States: IDLE, LOAD, STF_REQ, STF_OUT, LTF_LOAD, LTF_REQ, LTF_OUT, FLUSH.
REQ-014 IDLE: tx_start with n_ltf in 1..4 latches coefficients and n_ltf, pulses stf_letsgo and ltf_letsgo for one cycle each, and enters LOAD; tx_start with n_ltf 0 or >4 pulses err and stays in IDLE.
REQ-015 LOAD and LTF_LOAD: count LOAD_CYC cycles, then enter STF_REQ or LTF_REQ respectively.
REQ-016 *_REQ: pulse the matching *_give for one cycle on entry, then wait for *_started; timeout after START_TIMEOUT cycles goes to FLUSH with err.
REQ-017 *_OUT: the first cycle with *_started high is sample 0; forward exactly SYM_LEN consecutive samples, one per cycle, with ht_valid high and ht_sample registered (1-cycle latency from generator sample).
REQ-018 After STF_OUT, set ltf index k=1 and enter LTF_REQ (the LTF generator is already loaded).
REQ-019 After LTF_OUT with k<n_ltf: increment k, pulse ltf_letsgo, enter LTF_LOAD. With k==n_ltf: pulse done, enter IDLE.
REQ-020 P-row polarity: for LTF index k==2, negate I and Q; negating -32768 saturates to +32767; all other symbols pass through unchanged.
REQ-021 ht_sym holds the index of the symbol currently on ht_sample; ht_valid stays low in all non-OUT cycles (inter-symbol gaps permitted).
REQ-022 tx_start while busy is ignored, with no err.
REQ-023 tx_abort in any non-IDLE state enters FLUSH; abort wins over simultaneous start, timeout, or last sample.
REQ-024 FLUSH: assert gen_reset for 2 cycles with ht_valid low, then enter IDLE; no done pulse is issued.
REQ-025 busy = state != IDLE.

Reset
REQ-026 rstn low asynchronously forces IDLE, zeros all counters and latched coefficients, and drives every output to 0 except gen_reset.
REQ-027 gen_reset = 1 while rstn is low and for the first cycle after release.

Structure
REQ-028 The state encoding and the SYM_LEN, LOAD_CYC and START_TIMEOUT defaults belong in shared package ht_tx_pkg.
REQ-029 One sub-module, ht_iq_negsat: a combinational saturating 16-bit I/Q negator.

Verification
REQ-030 n_ltf=1 with generator models using started delay 2: stream of 160 valid samples (ht_sym 0 for 80, then 1 for 80), one done pulse, err=0.
REQ-031 n_ltf=2 with LTF sample 0x8000_7FFF: symbol 2 outputs 0x7FFF_8001, and ltf_letsgo pulses twice in total.
REQ-032 stf_started held low: err pulses 16 cycles after stf_give, gen_reset high for 2 cycles, then IDLE.
REQ-033 tx_abort at STF sample 40: ht_valid low on the next cycle, no done pulse, and a subsequent tx_start succeeds.
REQ-034 tx_start with n_ltf=0: err pulse, no letsgo, busy=0; tx_start while busy has no effect.
REQ-035 rstn asserted mid-LTF_OUT: outputs 0 immediately, gen_reset=1, IDLE after release.
